box_pixel_reader: RTL and testbench

Frame-buffer read side of the six-box filter display. For each raster position it decides which of the six 240x320 preview boxes contains the position, computes the image-local BRAM address, and issues the read. It returns the 12-bit pixel aligned with the delayed hcount/vcount, so the display compositor sees frame-buffer data in step with its timing. It also owns the front/back bank select of the double-buffered image store, swapping banks only at frame boundaries when the capture writer requests it.

---
 rtl/box_layout_pkg.sv | 19 +
 rtl/pipe_delay.sv | 37 +++
 rtl/box_pixel_reader.sv | 165 ++++++++++++++++
 tb/tb_box_pixel_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/box_layout_pkg.sv
// Shared six-box preview geometry used by the frame-buffer reader and the display compositor.
// Box index = row*3 + col, row 0 is the top row; NO_BOX marks raster positions outside all boxes.
package box_layout_pkg;

    localparam int IMG_W = 240;
    localparam int IMG_H = 320;

    localparam logic [2:0][10:0] BOX_X0 = {11'd730, 11'd390, 11'd50};
    localparam logic [1:0][9:0]  BOX_Y0 = {10'd446, 10'd26};

    typedef logic [2:0] box_id_t;
    localparam box_id_t NO_BOX = 3'd7;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

endpackage

// File: rtl/pipe_delay.sv
// Fixed-depth register delay line with a configurable reset value.
module pipe_delay #(
    parameter int                WIDTH     = 1,
    parameter int                DEPTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;
    logic [DEPTH-1:0][WIDTH-1:0] stage_d;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign stage_d[gi] = din;
            end else begin : g_rest
                assign stage_d[gi] = stage_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            stage_q <= {DEPTH{RESET_VAL}};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/box_pixel_reader.sv
// Frame-buffer read side: maps raster position to box/local address, issues the BRAM read and
// realigns the returned pixel with delayed timing; also owns the front/back bank select.
module box_pixel_reader #(
    parameter int IMG_W        = 240,
    parameter int IMG_H        = 320,
    parameter int BRAM_LATENCY = 2,
    parameter int ADDR_W       = 17
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              swap_req_in,
    input  logic [11:0]       bram_data_in,
    output logic [ADDR_W:0]   addr_out,
    output logic              rd_en_out,
    output logic [11:0]       pixel_out,
    output logic              in_box_out,
    output logic [2:0]        box_out,
    output logic [10:0]       hcount_out,
    output logic [9:0]        vcount_out,
    output logic              swap_ack_out,
    output logic              bank_out
);
    import box_layout_pkg::*;

    logic [2:0]      hit_x;
    logic [1:0]      hit_y;
    logic [2:0][7:0] x_off;
    logic [1:0][8:0] y_off;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_col
            assign hit_x[gi] = (hcount_in >= BOX_X0[gi]) &&
                               ({1'b0, hcount_in} < ({1'b0, BOX_X0[gi]} + 12'(IMG_W)));
            assign x_off[gi] = 8'(hcount_in - BOX_X0[gi]);
        end
        for (gi = 0; gi < 2; gi++) begin : g_row
            assign hit_y[gi] = (vcount_in >= BOX_Y0[gi]) &&
                               ({1'b0, vcount_in} < ({1'b0, BOX_Y0[gi]} + 11'(IMG_H)));
            assign y_off[gi] = 9'(vcount_in - BOX_Y0[gi]);
        end
    endgenerate

    // Swap FSM: state register / next state / outputs
    swap_state_t state_q, state_d;
    logic        boundary;
    logic        do_swap;

    assign boundary = (hcount_in == 11'd0) && (vcount_in == 10'd0);

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= SWAP_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SWAP_IDLE:    if (swap_req_in && !boundary) state_d = SWAP_PENDING;
            SWAP_PENDING: if (boundary)                 state_d = SWAP_IDLE;
            default:                                    state_d = SWAP_IDLE;
        endcase
    end

    always_comb begin
        do_swap = boundary && ((state_q == SWAP_PENDING) || swap_req_in);
    end

    // Stage 1: box decode and local coordinates
    logic        bank_q, bank_d, ack_q, ack_d;
    logic        in_box_q, in_box_d, s1_bank_q;
    box_id_t     box_q, box_d;
    logic [7:0]  lx_q, lx_d;
    logic [8:0]  ly_q, ly_d;
    logic [1:0]  col;
    logic        row;
    logic [7:0]  x_sel;
    logic [8:0]  y_sel;

    always_comb begin
        col   = 2'd0;
        x_sel = x_off[0];
        if (hit_x[1]) begin
            col   = 2'd1;
            x_sel = x_off[1];
        end else if (hit_x[2]) begin
            col   = 2'd2;
            x_sel = x_off[2];
        end
        row   = hit_y[1];
        y_sel = hit_y[1] ? y_off[1] : y_off[0];

        in_box_d = (|hit_x) && (|hit_y);
        box_d    = in_box_d ? box_id_t'({2'b00, row} * 3'd3 + {1'b0, col}) : NO_BOX;
        lx_d     = in_box_d ? x_sel : 8'd0;
        ly_d     = in_box_d ? y_sel : 9'd0;
        // A pixel sampled on the boundary cycle already belongs to the new frame's bank.
        bank_d   = bank_q ^ do_swap;
        ack_d    = do_swap;
    end

    // Stage 2: y*240 + x via shifts
    logic [ADDR_W:0]   addr_q, addr_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] local_addr;

    always_comb begin
        local_addr = ADDR_W'({ly_q, 8'b0}) - ADDR_W'({ly_q, 4'b0}) + ADDR_W'(lx_q);
        addr_d     = {s1_bank_q, in_box_q ? local_addr : {ADDR_W{1'b0}}};
        rd_en_d    = in_box_q;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            bank_q    <= 1'b0;
            ack_q     <= 1'b0;
            in_box_q  <= 1'b0;
            s1_bank_q <= 1'b0;
            box_q     <= NO_BOX;
            lx_q      <= 8'd0;
            ly_q      <= 9'd0;
            addr_q    <= '0;
            rd_en_q   <= 1'b0;
        end else begin
            bank_q    <= bank_d;
            ack_q     <= ack_d;
            in_box_q  <= in_box_d;
            s1_bank_q <= bank_d;
            box_q     <= box_d;
            lx_q      <= lx_d;
            ly_q      <= ly_d;
            addr_q    <= addr_d;
            rd_en_q   <= rd_en_d;
        end
    end

    assign addr_out     = addr_q;
    assign rd_en_out    = rd_en_q;
    assign bank_out     = bank_q;
    assign swap_ack_out = ack_q;

    pipe_delay #(.WIDTH(1), .DEPTH(BRAM_LATENCY), .RESET_VAL(1'b0)) u_in_box_dly (
        .clk_in(clk_in), .rst_in(rst_in), .din(rd_en_q), .dout(in_box_out)
    );

    pipe_delay #(.WIDTH(3), .DEPTH(1 + BRAM_LATENCY), .RESET_VAL(NO_BOX)) u_box_dly (
        .clk_in(clk_in), .rst_in(rst_in), .din(box_q), .dout(box_out)
    );

    pipe_delay #(.WIDTH(11), .DEPTH(2 + BRAM_LATENCY), .RESET_VAL(11'd0)) u_hcount_dly (
        .clk_in(clk_in), .rst_in(rst_in), .din(hcount_in), .dout(hcount_out)
    );

    pipe_delay #(.WIDTH(10), .DEPTH(2 + BRAM_LATENCY), .RESET_VAL(10'd0)) u_vcount_dly (
        .clk_in(clk_in), .rst_in(rst_in), .din(vcount_in), .dout(vcount_out)
    );

    assign pixel_out = in_box_out ? bram_data_in : 12'd0;

endmodule

// File: tb/tb_box_pixel_reader.sv
// Bench for box_pixel_reader: directed raster points, a row scan, bank-swap and reset cases, then
// random positions, all checked against a geometric reference model with a latency-2 BRAM model.
module tb_box_pixel_reader;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic [10:0] hcount_in = '0;
    logic [9:0]  vcount_in = '0;
    logic        swap_req_in = 1'b0;
    logic [11:0] bram_data_in;
    logic [17:0] addr_out;
    logic        rd_en_out;
    logic [11:0] pixel_out;
    logic        in_box_out;
    logic [2:0]  box_out;
    logic [10:0] hcount_out;
    logic [9:0]  vcount_out;
    logic        swap_ack_out;
    logic        bank_out;

    box_pixel_reader dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .swap_req_in(swap_req_in), .bram_data_in(bram_data_in),
        .addr_out(addr_out), .rd_en_out(rd_en_out),
        .pixel_out(pixel_out), .in_box_out(in_box_out), .box_out(box_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .swap_ack_out(swap_ack_out), .bank_out(bank_out)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int rd_cnt = 0;
    bit bank_m = 1'b0;
    bit pend_m = 1'b0;
    logic [31:0] salt;

    typedef struct {
        logic [17:0] addr;
        logic        rd;
        logic [2:0]  box;
        logic        inb;
        logic [10:0] h;
        logic [9:0]  v;
    } exp_t;

    exp_t q[$];

    function automatic logic [11:0] bram_word(logic [17:0] a);
        logic [31:0] t;
        t = ({14'b0, a} * 32'h9E3779B1) ^ salt;
        return t[23:12];
    endfunction

    // Latency-2 BRAM holding a hashed pattern across both banks
    logic [11:0] bq1 = '0, bq2 = '0;
    always @(posedge clk_in) begin
        if (rd_en_out) bq1 <= bram_word(addr_out);
        bq2 <= bq1;
    end
    assign bram_data_in = bq2;

    function automatic exp_t model(int h, int v, bit bank);
        exp_t e;
        int xs[3];
        int ys[2];
        xs = '{50, 390, 730};
        ys = '{26, 446};
        e.addr = {bank, 17'd0};
        e.rd = 1'b0; e.inb = 1'b0; e.box = 3'd7;
        e.h = 11'(h); e.v = 10'(v);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                if (h >= xs[c] && h < xs[c] + 240 && v >= ys[r] && v < ys[r] + 320) begin
                    e.inb = 1'b1; e.rd = 1'b1;
                    e.box = 3'(r * 3 + c);
                    e.addr = {bank, 17'((v - ys[r]) * 240 + (h - xs[c]))};
                end
        return e;
    endfunction

    function automatic exp_t reset_entry();
        exp_t e;
        e.addr = '0; e.rd = 1'b0; e.box = 3'd7; e.inb = 1'b0; e.h = '0; e.v = '0;
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(int h, int v, bit req);
        exp_t e, a, o;
        bit exp_ack;
        int n;
        hcount_in = 11'(h);
        vcount_in = 10'(v);
        swap_req_in = req;
        exp_ack = 1'b0;
        if (h == 0 && v == 0 && (pend_m || req)) begin
            bank_m = ~bank_m;
            pend_m = 1'b0;
            exp_ack = 1'b1;
        end else if (req) begin
            pend_m = 1'b1;
        end
        e = model(h, v, bank_m);
        q.push_back(e);
        @(posedge clk_in); #1;
        swap_req_in = 1'b0;
        if (rd_en_out) rd_cnt++;
        check("swap_ack", swap_ack_out, exp_ack);
        check("bank_out", bank_out, bank_m);
        n = q.size();
        a = q[n-2];
        o = q[n-4];
        check("addr_out", addr_out, a.addr);
        check("rd_en_out", rd_en_out, a.rd);
        check("in_box_out", in_box_out, o.inb);
        check("box_out", box_out, o.box);
        check("hcount_out", hcount_out, o.h);
        check("vcount_out", vcount_out, o.v);
        check("pixel_out", pixel_out, o.inb ? bram_word(o.addr) : 12'd0);
        void'(q.pop_front());
    endtask

    task automatic do_reset();
        #3;
        rst_in = 1'b0;
        #1;
        check("rst_pixel", pixel_out, 0);
        check("rst_in_box", in_box_out, 0);
        check("rst_box", box_out, 7);
        check("rst_bank", bank_out, 0);
        check("rst_ack", swap_ack_out, 0);
        check("rst_rd_en", rd_en_out, 0);
        check("rst_addr", addr_out, 0);
        check("rst_hcount", hcount_out, 0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        bank_m = 1'b0;
        pend_m = 1'b0;
        q.delete();
        repeat (4) q.push_back(reset_entry());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int h, v, xs[3], ys[2];
        xs = '{50, 390, 730};
        ys = '{26, 446};
        salt = $urandom;
        #2;
        do_reset();

        // Directed points, including box edges
        step(50, 26, 0);
        step(969, 765, 0);
        step(970, 765, 0);
        check("addr_max", addr_out, 18'd76799);
        step(289, 26, 0);
        step(290, 26, 0);
        step(390, 100, 0);
        step(49, 26, 0);
        check("addr_box1", addr_out, 18'd17760);
        step(50, 25, 0);
        step(50, 345, 0);
        step(50, 346, 0);
        step(730, 446, 0);
        step(1000, 0, 0);
        step(1000, 0, 0);

        // One full line through the top row of boxes
        rd_cnt = 0;
        for (int x = 0; x < 1100; x++) step(x, 100, 0);
        step(1050, 100, 0);
        step(1050, 100, 0);
        check("row_reads", rd_cnt, 720);

        // Mid-frame request, swap at the boundary, first box pixel from bank 1
        step(100, 100, 1);
        step(120, 100, 0);
        step(500, 500, 0);
        step(0, 0, 0);
        step(50, 26, 0);
        step(51, 26, 0);
        check("new_bank_addr_bit", addr_out[17], 1);
        // Two requests in one frame give one swap
        step(300, 300, 1);
        step(400, 400, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(50, 26, 0);

        // Reset while a swap is pending drops the request
        step(100, 100, 1);
        step(60, 30, 0);
        do_reset();
        step(0, 0, 0);
        step(50, 26, 0);
        step(51, 26, 0);
        step(52, 26, 0);
        step(53, 26, 0);

        // Random positions, biased towards box edges, with occasional swaps and boundaries
        for (int i = 0; i < 2500; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    h = xs[$urandom_range(0, 2)] + ($urandom_range(0, 1) ? 238 : -1) + $urandom_range(0, 2);
                    v = ys[$urandom_range(0, 1)] + ($urandom_range(0, 1) ? 318 : -1) + $urandom_range(0, 2);
                end
                default: begin
                    h = $urandom_range(0, 1100);
                    v = $urandom_range(0, 800);
                end
            endcase
            if ($urandom_range(0, 63) == 0) begin
                h = 0;
                v = 0;
            end
            step(h, v, $urandom_range(0, 39) == 0);
        end
        repeat (4) step(1100, 800, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
